// File: rtl/sync_timing_lock.sv
// Line/frame timing qualifier placed behind the HSYNC/VSYNC detectors. It measures the line period
// and the lines per frame, locks after repeated matching frames, and publishes stable timing.
module sync_timing_lock #(
    parameter int HCNT_WIDTH    = 12,
    parameter int LCNT_WIDTH    = 10,
    parameter int PERIOD_TOL    = 2,
    parameter int LOCK_FRAMES   = 3,
    parameter int UNLOCK_FRAMES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  HSyncPulse,
    input  logic                  HSyncValid,
    input  logic                  VSyncPulse,
    input  logic                  VSyncValid,
    output logic [HCNT_WIDTH-1:0] LinePeriod,
    output logic [LCNT_WIDTH-1:0] LinesPerFrame,
    output logic [LCNT_WIDTH-1:0] LineIndex,
    output logic                  Locked,
    output logic                  ModeChange
);
    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam int UW = $clog2(UNLOCK_FRAMES + 1);
    localparam logic [HCNT_WIDTH-1:0] HMAX   = {HCNT_WIDTH{1'b1}};
    localparam logic [HCNT_WIDTH-1:0] HONE   = HCNT_WIDTH'(1);
    localparam logic [HCNT_WIDTH-1:0] TOL_V  = HCNT_WIDTH'(PERIOD_TOL);
    localparam logic [LCNT_WIDTH-1:0] LMAX   = {LCNT_WIDTH{1'b1}};
    localparam logic [LCNT_WIDTH-1:0] LONE   = LCNT_WIDTH'(1);
    localparam logic [MW-1:0]         MONE   = MW'(1);
    localparam logic [MW-1:0]         LOCK_N = MW'(LOCK_FRAMES);
    localparam logic [UW-1:0]         UONE   = UW'(1);
    localparam logic [UW-1:0]         UNLK_N = UW'(UNLOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [HCNT_WIDTH-1:0]   hCnt_r, lastPeriod_r, refPeriod_r, linePeriod_r;
    logic [LCNT_WIDTH-1:0]   lCnt_r, refLines_r, linesPerFrame_r;
    logic [MW-1:0]           matchCnt_r;
    logic [UW-1:0]           missCnt_r;
    logic                    frameBad_r, locked_r, modeChange_r;

    logic [HCNT_WIDTH-1:0]   period_s, periodDiff_s, curPeriod_s;
    logic [LCNT_WIDTH-1:0]   frameLines_s;
    logic                    hOvf_s, lSat_s, tolBad_s, lineBad_s, frameBadEff_s, good_s, validOk_s;

    // Per-line measurement and end-of-frame verdict, folding in a same-cycle HSync line.
    always_comb begin
        hOvf_s       = (hCnt_r == HMAX);
        lSat_s       = (lCnt_r == LMAX);
        period_s     = hOvf_s ? HMAX : (hCnt_r + HONE);
        periodDiff_s = (period_s > refPeriod_r) ? (period_s - refPeriod_r) : (refPeriod_r - period_s);
        tolBad_s     = (state_r != ST_SEARCH) && (periodDiff_s > TOL_V);
        lineBad_s    = HSyncPulse && (hOvf_s || lSat_s || tolBad_s);
        frameBadEff_s = frameBad_r || lineBad_s;
        curPeriod_s  = HSyncPulse ? period_s : lastPeriod_r;
        if (HSyncPulse && !lSat_s) begin
            frameLines_s = lCnt_r + LONE;
        end else begin
            frameLines_s = lCnt_r;
        end
        good_s    = !frameBadEff_s && (frameLines_s == refLines_r);
        validOk_s = HSyncValid && VSyncValid;
    end

    // Saturating line-period and line counters with the per-frame bad flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hCnt_r       <= {HCNT_WIDTH{1'b0}};
            lastPeriod_r <= {HCNT_WIDTH{1'b0}};
            lCnt_r       <= {LCNT_WIDTH{1'b0}};
            frameBad_r   <= 1'b0;
        end else begin
            if (HSyncPulse) begin
                hCnt_r       <= {HCNT_WIDTH{1'b0}};
                lastPeriod_r <= period_s;
            end else if (!hOvf_s) begin
                hCnt_r <= hCnt_r + HONE;
            end
            if (VSyncPulse) begin
                lCnt_r     <= {LCNT_WIDTH{1'b0}};
                frameBad_r <= 1'b0;
            end else if (HSyncPulse) begin
                if (!lSat_s) begin
                    lCnt_r <= lCnt_r + LONE;
                end
                frameBad_r <= frameBadEff_s;
            end
        end
    end

    // Lock/unlock hysteresis; a dropped valid overrides everything, including a same-cycle VSync.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r         <= ST_SEARCH;
            refPeriod_r     <= {HCNT_WIDTH{1'b0}};
            refLines_r      <= {LCNT_WIDTH{1'b0}};
            matchCnt_r      <= {MW{1'b0}};
            missCnt_r       <= {UW{1'b0}};
            linePeriod_r    <= {HCNT_WIDTH{1'b0}};
            linesPerFrame_r <= {LCNT_WIDTH{1'b0}};
            locked_r        <= 1'b0;
            modeChange_r    <= 1'b0;
        end else begin
            modeChange_r <= 1'b0;
            if (!validOk_s) begin
                state_r    <= ST_SEARCH;
                locked_r   <= 1'b0;
                matchCnt_r <= {MW{1'b0}};
                missCnt_r  <= {UW{1'b0}};
            end else if (VSyncPulse) begin
                case (state_r)
                    ST_SEARCH: begin
                        refPeriod_r <= curPeriod_s;
                        refLines_r  <= frameLines_s;
                        matchCnt_r  <= {MW{1'b0}};
                        state_r     <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (!good_s) begin
                            refPeriod_r <= curPeriod_s;
                            refLines_r  <= frameLines_s;
                            matchCnt_r  <= {MW{1'b0}};
                        end else if ((matchCnt_r + MONE) == LOCK_N) begin
                            state_r         <= ST_LOCKED;
                            locked_r        <= 1'b1;
                            matchCnt_r      <= {MW{1'b0}};
                            missCnt_r       <= {UW{1'b0}};
                            linePeriod_r    <= refPeriod_r;
                            linesPerFrame_r <= refLines_r;
                            modeChange_r    <= (refPeriod_r != linePeriod_r) || (refLines_r != linesPerFrame_r);
                        end else begin
                            matchCnt_r <= matchCnt_r + MONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (good_s) begin
                            missCnt_r <= {UW{1'b0}};
                        end else if ((missCnt_r + UONE) == UNLK_N) begin
                            state_r   <= ST_SEARCH;
                            locked_r  <= 1'b0;
                            missCnt_r <= {UW{1'b0}};
                        end else begin
                            missCnt_r <= missCnt_r + UONE;
                        end
                    end
                    default: begin
                        state_r  <= ST_SEARCH;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign LinePeriod    = linePeriod_r;
    assign LinesPerFrame = linesPerFrame_r;
    assign LineIndex     = lCnt_r;
    assign Locked        = locked_r;
    assign ModeChange    = modeChange_r;
endmodule

// File: tb/tb_sync_timing_lock.sv
// Bench for sync_timing_lock: frame-level scenario table, hand sequences and randomized frames,
// all compared cycle by cycle against an event-level reference model.
module tb_sync_timing_lock;
    localparam int HMAX = 4095;
    localparam int LMAX = 1023;
    localparam int TOL  = 2;
    localparam int LOCK_FR = 3;
    localparam int UNLOCK_FR = 2;

    logic        CLK, RST, HSyncPulse, HSyncValid, VSyncPulse, VSyncValid;
    logic [11:0] LinePeriod;
    logic [9:0]  LinesPerFrame, LineIndex;
    logic        Locked, ModeChange;

    sync_timing_lock dut (
        .CLK(CLK), .RST(RST),
        .HSyncPulse(HSyncPulse), .HSyncValid(HSyncValid),
        .VSyncPulse(VSyncPulse), .VSyncValid(VSyncValid),
        .LinePeriod(LinePeriod), .LinesPerFrame(LinesPerFrame),
        .LineIndex(LineIndex), .Locked(Locked), .ModeChange(ModeChange)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int per; int jit; int spikeIdx; int spikePer; int lines; int coin; int drop; int preIdle;
        int expLocked; int expPer; int expLines; int expMC;
    } row_t;

    row_t rows[$];
    row_t rr;
    int   nChecks = 0;
    int   nFail   = 0;
    int   idleSince = 0;
    int   basePer, baseLines;

    // Reference model: unbounded counts, clipped only where the published widths demand it.
    int mSince, mLines, mLastPer, mRefPer, mRefLines, mPhase, mGood, mMiss, mPubPer, mPubLines;
    bit mFrameBad, mLocked, mMC;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void modelReset();
        mSince = 0; mLines = 0; mLastPer = 0; mRefPer = 0; mRefLines = 0; mPhase = 0;
        mGood = 0; mMiss = 0; mPubPer = 0; mPubLines = 0; mFrameBad = 0; mLocked = 0; mMC = 0;
    endfunction

    function automatic void modelStep(input bit hs, input bit vs, input bit hv, input bit vv);
        int per, curPer, fl, dif;
        bit lineBad, fbad, good;
        mMC = 0;
        per = imin(mSince + 1, HMAX);
        dif = (per > mRefPer) ? per - mRefPer : mRefPer - per;
        lineBad = hs && ((mSince + 1 > HMAX) || (mLines >= LMAX) || (mPhase != 0 && dif > TOL));
        fbad = mFrameBad || lineBad;
        curPer = hs ? per : mLastPer;
        fl = imin(mLines + (hs ? 1 : 0), LMAX);
        good = !fbad && (fl == mRefLines);
        if (!hv || !vv) begin
            mPhase = 0; mLocked = 0; mGood = 0; mMiss = 0;
        end else if (vs) begin
            if (mPhase == 0) begin
                mRefPer = curPer; mRefLines = fl; mGood = 0; mPhase = 1;
            end else if (mPhase == 1) begin
                if (!good) begin
                    mRefPer = curPer; mRefLines = fl; mGood = 0;
                end else begin
                    mGood++;
                    if (mGood == LOCK_FR) begin
                        mPhase = 2; mLocked = 1; mGood = 0; mMiss = 0;
                        mMC = (mPubPer != mRefPer) || (mPubLines != mRefLines);
                        mPubPer = mRefPer; mPubLines = mRefLines;
                    end
                end
            end else begin
                if (good) mMiss = 0;
                else begin
                    mMiss++;
                    if (mMiss == UNLOCK_FR) begin
                        mPhase = 0; mLocked = 0; mMiss = 0;
                    end
                end
            end
        end
        if (hs) mLastPer = per;
        mSince = hs ? 0 : mSince + 1;
        if (vs) begin
            mLines = 0; mFrameBad = 0;
        end else if (hs) begin
            mLines++; mFrameBad = fbad;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        check("LinePeriod", int'(LinePeriod), mPubPer);
        check("LinesPerFrame", int'(LinesPerFrame), mPubLines);
        check("LineIndex", int'(LineIndex), imin(mLines, LMAX));
        check("Locked", int'(Locked), int'(mLocked));
        check("ModeChange", int'(ModeChange), int'(mMC));
    endtask

    task automatic driveCycle(input bit hs, input bit vs, input bit hv, input bit vv);
        HSyncPulse = hs; VSyncPulse = vs; HSyncValid = hv; VSyncValid = vv;
        modelStep(hs, vs, hv, vv);
        @(posedge CLK); #1;
        compareAll();
        idleSince = hs ? 0 : idleSince + 1;
    endtask

    task automatic doReset();
        RST = 1'b1; HSyncPulse = 1'b0; VSyncPulse = 1'b0; HSyncValid = 1'b1; VSyncValid = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        modelReset();
        idleSince = 0;
        check("reset_LinePeriod", int'(LinePeriod), 0);
        check("reset_LinesPerFrame", int'(LinesPerFrame), 0);
        check("reset_LineIndex", int'(LineIndex), 0);
        check("reset_Locked", int'(Locked), 0);
        check("reset_ModeChange", int'(ModeChange), 0);
    endtask

    // One frame: lines with exact HSync spacing, then VSync (coincident with the last HSync or one cycle later).
    task automatic sendFrame(input row_t r);
        int p;
        bit hv, vv;
        repeat (r.preIdle) driveCycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < r.lines; k++) begin
            p = r.per + (((k % 2) == 1) ? r.jit : -r.jit);
            if (k == r.spikeIdx) p = r.spikePer;
            while (idleSince < p - 1) begin
                hv = !(r.drop == 1 && k == 3 && idleSince == 0);
                vv = !(r.drop == 2 && k == 3 && idleSince == 0);
                driveCycle(1'b0, 1'b0, hv, vv);
                if (!hv || !vv) check("drop_unlock", int'(Locked), 0);
            end
            driveCycle(1'b1, (r.coin != 0) && (k == r.lines - 1), 1'b1, 1'b1);
        end
        if (r.coin == 0) driveCycle(1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // per jit sIdx sPer lines coin drop pre | Locked Per Lines MC
        repeat (3) rows.push_back('{36, 0, -1,  0, 12, 0, 0,    0, 0,  0,  0, 0});
        rows.push_back('{36, 0, -1,  0, 12, 0, 0,    0, 1, 36, 12, 1});
        rows.push_back('{36, 2, -1,  0, 12, 0, 0,    0, 1, 36, 12, 0});
        rows.push_back('{36, 0,  5, 39, 12, 0, 0,    0, 1, 36, 12, 0});
        rows.push_back('{36, 0, -1,  0, 12, 0, 0,    0, 1, 36, 12, 0});
        rows.push_back('{36, 0,  5, 39, 12, 0, 0,    0, 1, 36, 12, 0});
        rows.push_back('{36, 0, -1,  0, 12, 0, 0,    0, 1, 36, 12, 0});
        rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 1, 36, 12, 0});
        repeat (4) rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 0, 36, 12, 0});
        rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 1, 36, 13, 1});
        rows.push_back('{36, 0, -1,  0, 13, 0, 1,    0, 0, 36, 13, 0});
        repeat (2) rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 0, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 1, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 13, 1, 0,    0, 1, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 12, 1, 0,    0, 1, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 13, 1, 0,    0, 1, 36, 13, 0});
        rows.push_back('{36, 0, 12, 40, 13, 1, 0,    0, 1, 36, 13, 0});
        rows.push_back('{36, 0, 12, 40, 13, 1, 0,    0, 0, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 0, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 13, 0, 0, 4200, 0, 36, 13, 0});
        repeat (2) rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 0, 36, 13, 0});
        rows.push_back('{36, 0, -1,  0, 13, 0, 0,    0, 1, 36, 13, 0});

        doReset();
        foreach (rows[i]) begin
            sendFrame(rows[i]);
            check($sformatf("row%0d_Locked", i), int'(Locked), rows[i].expLocked);
            check($sformatf("row%0d_LinePeriod", i), int'(LinePeriod), rows[i].expPer);
            check($sformatf("row%0d_LinesPerFrame", i), int'(LinesPerFrame), rows[i].expLines);
            check($sformatf("row%0d_ModeChange", i), int'(ModeChange), rows[i].expMC);
            check($sformatf("row%0d_LineIndex", i), int'(LineIndex), 0);
        end

        // Reset in the middle of a frame while locked.
        for (int k = 0; k < 5; k++) begin
            while (idleSince < 35) driveCycle(1'b0, 1'b0, 1'b1, 1'b1);
            driveCycle(1'b1, 1'b0, 1'b1, 1'b1);
        end
        check("midframe_LineIndex", int'(LineIndex), 5);
        check("midframe_Locked", int'(Locked), 1);
        doReset();
        rr = '{36, 0, -1, 0, 13, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            sendFrame(rr);
            check("relock_Locked", int'(Locked), (i == 3) ? 1 : 0);
            check("relock_ModeChange", int'(ModeChange), (i == 3) ? 1 : 0);
            check("relock_LinePeriod", int'(LinePeriod), (i == 3) ? 36 : 0);
        end

        // Randomized frames, checked only against the model.
        doReset();
        for (int f = 0; f < 60; f++) begin
            if ((f % 7) == 0) begin
                basePer   = 16 + int'($urandom_range(0, 10));
                baseLines = 5 + int'($urandom_range(0, 4));
            end
            rr.per      = basePer;
            rr.jit      = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : 3;
            rr.spikeIdx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            rr.spikePer = basePer + int'($urandom_range(3, 5));
            rr.lines    = baseLines + (($urandom_range(0, 7) == 0) ? 1 : 0);
            rr.coin     = int'($urandom_range(0, 1));
            rr.drop     = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
            rr.preIdle  = ($urandom_range(0, 39) == 0) ? 4100 : 0;
            sendFrame(rr);
        end

        HSyncPulse = 1'b0; VSyncPulse = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/sync_timing_lock.md
Name: sync_timing_lock

Overview:
- Sits directly downstream of the two sync detectors, one for HSYNC and one for VSYNC.
- Consumes their one-cycle sync pulses and valid flags.
- Measures line period in CLK cycles and lines per frame, and qualifies the measurements over consecutive frames with lock/unlock hysteresis.
- Publishes stable timing, a lock flag and a current line index to the capture/scaler logic feeding HDMI output.

Parameters:
HCNT_WIDTH, 12, width of the line-period counter; the counter saturates at 2^HCNT_WIDTH-1.
LCNT_WIDTH, 10, width of the line counter; the counter saturates at 2^LCNT_WIDTH-1.
PERIOD_TOL, 2, maximum allowed |line period - reference period| in clocks.
LOCK_FRAMES, 3, number of consecutive good frames needed to lock (>=1).
UNLOCK_FRAMES, 2, number of consecutive bad frames that drop lock (>=1).

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  reset, synchronous, active-high.
HSyncPulse  input  1  one-cycle HSYNC detected strobe.
HSyncValid  input  1  HSYNC detected in time.
VSyncPulse  input  1  one-cycle VSYNC detected strobe.
VSyncValid  input  1  VSYNC detected in time.
LinePeriod  output  HCNT_WIDTH  published line period in clocks.
LinesPerFrame  output  LCNT_WIDTH  published line count per frame.
LineIndex  output  LCNT_WIDTH  HSync pulses seen since the last VSync (live).
Locked  output  1  timing stable.
ModeChange  output  1  one-cycle pulse when published values change.

Behaviour:
- Reset (RST high at an edge):
  - all outputs 0; hcnt=0, lcnt=0, state=SEARCH.
  - refPeriod=0, refLines=0, matchCnt=0, missCnt=0, frameBad=0.
  - Reset mid-frame discards all measurements.
- hcnt:
  - +1 each cycle, saturating at all-ones.
  - On HSyncPulse: period=hcnt+1 and hcnt<=0. Pulses N cycles apart therefore give period=N.
  - period at saturation counts as an overflow.
- Line check on each HSyncPulse:
  - frameBad<=1 if period overflowed, or if |period-refPeriod|>PERIOD_TOL while state!=SEARCH.
  - lastPeriod<=period.
- lcnt:
  - +1 on HSyncPulse, saturating.
  - Saturation sets frameBad.
  - LineIndex=lcnt.
- VSyncPulse ends a frame:
  - frameLines = lcnt, plus 1 if HSyncPulse occurs in the same cycle (that line belongs to the ending frame); same-cycle HSync period check also applies to the ending frame.
  - Then lcnt<=0 and frameBad<=0 (the new frame starts clean).
  - good = !frameBad_eff && frameLines==refLines, where frameBad_eff includes any same-cycle HSync violation.
- Lock FSM (evaluated on VSyncPulse unless stated):
  - Override, any state: HSyncValid==0 or VSyncValid==0 in a cycle → next state SEARCH, Locked<=0, matchCnt/missCnt<=0. This has priority over all other transitions, including a same-cycle VSyncPulse.
  - SEARCH, on VSyncPulse with both valids: refPeriod<=lastPeriod (or the same-cycle period), refLines<=frameLines, matchCnt<=0 → ACQUIRE.
  - ACQUIRE, good: matchCnt+1. If matchCnt+1==LOCK_FRAMES → LOCKED, Locked<=1, LinePeriod<=refPeriod, LinesPerFrame<=refLines.
  - ACQUIRE, bad: reload refPeriod/refLines from this frame, matchCnt<=0, stay in ACQUIRE.
  - LOCKED, good: missCnt<=0; published values held.
  - LOCKED, bad: missCnt+1. If missCnt+1==UNLOCK_FRAMES → SEARCH, Locked<=0. LinePeriod/LinesPerFrame keep their last values.
- Locked rises in the cycle after the qualifying VSyncPulse and falls in the cycle after the unlock event or the valid drop.
- ModeChange:
  - pulses for exactly one cycle, coincident with Locked rising, when the newly published (LinePeriod, LinesPerFrame) differs from the previous published pair.
  - The first lock after reset always pulses (previous pair is 0,0).
- refPeriod is never updated while LOCKED; tolerance drift does not accumulate.

Test Plan:
1. Reset, then HSync every 636 clocks, 262 lines/frame, valids high → after VSync #1 ACQUIRE; Locked=1 one cycle after VSync #4; LinePeriod=636, LinesPerFrame=262; ModeChange single pulse.
2. Locked; line periods alternate 634/638 (within PERIOD_TOL=2) → stays locked; period 639 in one frame → missCnt=1, still locked; next frame clean → missCnt=0.
3. Locked; two consecutive frames of 263 lines → Locked=0 after the second VSync; outputs retain 636/262; relock to 263 takes 4 more VSyncs and ModeChange pulses.
4. HSyncValid forced low for one cycle while locked → Locked=0 next cycle; relock requires full SEARCH + 3 good frames; same timing → no ModeChange.
5. HSyncPulse and VSyncPulse in the same cycle ending a 261+1 line frame → frameLines=262, counted good; LineIndex=0 next cycle.
6. No HSync for >4095 clocks → hcnt saturates, frame bad; RST asserted mid-frame → all outputs 0 on the next edge, state SEARCH.
